tv_player: RTL and testbench

TV_PLAYER -- requirements
Module: tv_player

---
 rtl/tv_player.sv | 101 ++++++++++
 tb/tb_tv_player.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tv_player.sv
// tv_player: replays stored {a,b,c,yexp} vectors into a DUT and checks its response y
// after DUT_LAT cycles, counting mismatches and recording the first failing index.
module tv_player #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int DUT_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    input  logic [AW:0]   num_vec,
    input  logic          start,
    output logic          a,
    output logic          b,
    output logic          c,
    input  logic          y,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          err_pulse,
    output logic [7:0]    err_count,
    output logic [AW:0]   vec_count,
    output logic [AW-1:0] first_err_addr
);
    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;
    localparam logic [AW:0] DMAX = (AW+1)'(DEPTH);
    localparam int WL = (DUT_LAT > 0) ? DUT_LAT - 1 : 0;
    localparam logic [1:0] WEND = WL[1:0];
    state_t        r_state, w_next;
    logic [3:0]    r_mem [DEPTH];
    logic [AW:0]   r_lim;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_wcnt;
    logic          r_yexp;
    logic          w_open, w_go, w_last, w_miss;
    logic [AW:0]   w_lim;
    assign w_open = (r_state == IDLE) || (r_state == DONE);
    assign w_go   = w_open && start;
    assign w_lim  = (num_vec > DMAX) ? DMAX : num_vec;
    assign w_last = ({1'b0, r_idx} + 1'b1) == r_lim;
    assign w_miss = (r_state == CHECK) && (y != r_yexp);
    assign busy   = (r_state == APPLY) || (r_state == WAIT) || (r_state == CHECK);
    assign done   = r_state == DONE;
    assign pass   = done && (err_count == 8'd0);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = (w_lim == '0) ? DONE : APPLY;
            APPLY:      w_next = (DUT_LAT == 0) ? CHECK : WAIT;
            WAIT:       if (r_wcnt == WEND) w_next = CHECK;
            CHECK:      w_next = w_last ? DONE : APPLY;
            default:    w_next = IDLE;
        endcase
    end
    // Vector memory is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && w_open) r_mem[wr_addr] <= wr_data;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {a, b, c}      <= 3'b000;
            r_yexp         <= 1'b0;
            err_pulse      <= 1'b0;
            err_count      <= 8'd0;
            vec_count      <= '0;
            first_err_addr <= '0;
            r_lim          <= '0;
            r_idx          <= '0;
            r_wcnt         <= 2'd0;
        end else begin
            err_pulse <= w_miss;
            if (w_go) begin
                err_count      <= 8'd0;
                vec_count      <= '0;
                first_err_addr <= '0;
                r_lim          <= w_lim;
                r_idx          <= '0;
            end
            if (r_state == APPLY) begin
                {a, b, c} <= r_mem[r_idx][3:1];
                r_yexp    <= r_mem[r_idx][0];
                r_wcnt    <= 2'd0;
            end
            if (r_state == WAIT) r_wcnt <= r_wcnt + 2'd1;
            if (r_state == CHECK) begin
                if (w_miss) begin
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    if (err_count == 8'd0) first_err_addr <= r_idx;
                end
                vec_count <= vec_count + 1'b1;
                r_idx     <= r_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tv_player.sv
// tb_tv_player: directed table-driven checks of tv_player against a one-cycle-latency
// DUT model y = a ^ (b & c), plus hand sequences for reset, collisions and saturation.
module tb_tv_player;
    logic       clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0, y, y_flip = 1'b0, r_dy = 1'b0;
    logic [3:0] wr_addr = '0, wr_data = '0;
    logic [4:0] num_vec = '0;
    logic       a, b, c, busy, done, pass, err_pulse;
    logic [7:0] err_count;
    logic [4:0] vec_count;
    logic [3:0] first_err_addr;
    logic       bwr_en = 1'b0, bstart = 1'b0, by = 1'b0;
    logic [7:0] bwr_addr = '0;
    logic [3:0] bwr_data = '0;
    logic [8:0] bnum = '0;
    logic       ba, bb, bc, bbusy, bdone, bpass, bpulse;
    logic [7:0] berr, bfirst;
    logic [8:0] bvec;
    int total = 0, bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) r_dy <= a ^ (b & c);
    assign y = r_dy ^ y_flip;

    tv_player u_dut (.clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vec(num_vec), .start(start), .a(a), .b(b), .c(c), .y(y), .busy(busy), .done(done),
        .pass(pass), .err_pulse(err_pulse), .err_count(err_count), .vec_count(vec_count),
        .first_err_addr(first_err_addr));

    tv_player #(.DEPTH(256), .AW(8), .DUT_LAT(1)) u_big (.clk(clk), .reset(reset), .wr_en(bwr_en),
        .wr_addr(bwr_addr), .wr_data(bwr_data), .num_vec(bnum), .start(bstart), .a(ba), .b(bb),
        .c(bc), .y(by), .busy(bbusy), .done(bdone), .pass(bpass), .err_pulse(bpulse),
        .err_count(berr), .vec_count(bvec), .first_err_addr(bfirst));

    typedef struct {
        int          n;
        logic [15:0] mask;
        int          exp_err;
        int          exp_vec;
        int          exp_first;
        int          exp_busy;
        int          exp_pass;
    } run_t;
    run_t tbl[6];

    function automatic logic [2:0] vabc(int i);
        logic [2:0] v;
        v = 3'(i);
        if (i >= 8) v = v ^ 3'b101;
        return v;
    endfunction

    function automatic logic fy(logic [2:0] v);
        return v[2] ^ (v[1] & v[0]);
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(logic [15:0] m);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = {vabc(i), fy(vabc(i)) ^ m[i]};
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic kick(int n);
        @(negedge clk);
        num_vec = 5'(n);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int busy_n, output int pulses, output int toggled);
        logic [2:0] abc0;
        abc0    = {a, b, c};
        busy_n  = 0;
        pulses  = 0;
        toggled = 0;
        for (int k = 0; k < 300; k++) begin
            if (err_pulse) pulses++;
            if (busy) busy_n++;
            if ({a, b, c} != abc0) toggled = 1;
            if (done) break;
            @(negedge clk);
        end
        chk("done_reached", int'(done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bn, pl, tg;
        tbl[0] = '{8,  16'h0000, 0, 8,  0, 24, 1};
        tbl[1] = '{8,  16'h0024, 2, 8,  2, 24, 0};
        tbl[2] = '{0,  16'h0000, 0, 0,  0, 0,  1};
        tbl[3] = '{20, 16'h0000, 0, 16, 0, 48, 1};
        tbl[4] = '{16, 16'h8200, 2, 16, 9, 48, 0};
        tbl[5] = '{1,  16'h0001, 1, 1,  0, 3,  0};

        repeat (3) @(negedge clk);
        chk("reset_abc", int'({a, b, c}), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pass", int'(pass), 0);
        chk("reset_err_count", int'(err_count), 0);
        chk("reset_vec_count", int'(vec_count), 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            load(tbl[i].mask);
            kick(tbl[i].n);
            wait_done(bn, pl, tg);
            chk($sformatf("t%0d_busy_cycles", i), bn, tbl[i].exp_busy);
            chk($sformatf("t%0d_err_pulses", i), pl, tbl[i].exp_err);
            chk($sformatf("t%0d_err_count", i), int'(err_count), tbl[i].exp_err);
            chk($sformatf("t%0d_vec_count", i), int'(vec_count), tbl[i].exp_vec);
            chk($sformatf("t%0d_first_err", i), int'(first_err_addr), tbl[i].exp_first);
            chk($sformatf("t%0d_pass", i), int'(pass), tbl[i].exp_pass);
            if (tbl[i].n == 0) chk($sformatf("t%0d_abc_toggled", i), tg, 0);
            else chk($sformatf("t%0d_abc_last", i), int'({a, b, c}), int'(vabc(tbl[i].exp_vec - 1)));
        end

        // Write to vector 0 in the same cycle as start: vector 0 must see the new data.
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = {vabc(0), fy(vabc(0))};
        kick(1);
        wr_en = 1'b0;
        wait_done(bn, pl, tg);
        chk("coincide_err_count", int'(err_count), 0);
        chk("coincide_pass", int'(pass), 1);

        // Writes and starts during a run are ignored.
        load(16'h0000);
        kick(8);
        repeat (3) @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 4'd6;
        wr_data = {vabc(6), ~fy(vabc(6))};
        num_vec = 5'd1;
        start   = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        wait_done(bn, pl, tg);
        chk("busy_start_vec_count", int'(vec_count), 8);
        chk("busy_write_err_count", int'(err_count), 0);
        kick(8);
        wait_done(bn, pl, tg);
        chk("busy_write_rerun_err", int'(err_count), 0);

        // Reset in the middle of vector 3, then restart on the untouched memory.
        load(16'h0024);
        kick(8);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_abc", int'({a, b, c}), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done_pass", int'({done, pass, err_pulse}), 0);
        chk("midreset_err_count", int'(err_count), 0);
        chk("midreset_vec_count", int'(vec_count), 0);
        chk("midreset_first_err", int'(first_err_addr), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("postreset_idle", int'({busy, done}), 0);
        kick(8);
        wait_done(bn, pl, tg);
        chk("rerun_err_count", int'(err_count), 2);
        chk("rerun_first_err", int'(first_err_addr), 2);
        chk("rerun_vec_count", int'(vec_count), 8);
        chk("rerun_pass", int'(pass), 0);

        // 256 vectors against a constantly wrong y: count must stop at 255.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bwr_en   = 1'b1;
            bwr_addr = 8'(i);
            bwr_data = 4'b0001;
        end
        @(negedge clk);
        bwr_en = 1'b0;
        bnum   = 9'd300;
        bstart = 1'b1;
        @(negedge clk);
        bstart = 1'b0;
        for (int k = 0; k < 1000 && !bdone; k++) @(negedge clk);
        chk("big_done", int'(bdone), 1);
        chk("big_err_sat", int'(berr), 255);
        chk("big_vec_count", int'(bvec), 256);
        chk("big_first_err", int'(bfirst), 0);
        chk("big_pass", int'(bpass), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
